// File: rtl/rca_pkg.sv
// Shared definitions for the slice-serial ripple-carry word adder: default
// slice width, the sequencer FSM encoding and the slice counter sizing rule.
package rca_pkg;

    localparam int RCA_SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_state_e;

    // Counter must hold NSLICE-1 and stay at least one bit wide when NSLICE is 1.
    function automatic int rca_cnt_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational W-bit ripple-carry adder; the sequencer reuses one
// instance every cycle to add a single slice of the operand words.
module ripple_carry_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] chain_s;

    // Bit-serial carry chain from bit 0 to bit W-1.
    always_comb begin
        chain_s    = '0;
        sum_o      = '0;
        chain_s[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]       = a_i[i] ^ b_i[i] ^ chain_s[i];
            chain_s[i + 1] = (a_i[i] & b_i[i]) | (chain_s[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = chain_s[W];
    end

endmodule

// File: rtl/rca_word_sequencer.sv
// Word adder that processes WIDTH/SLICE_W slices through one shared ripple
// adder, one slice per clock, with a valid/ready handshake on both sides.
module rca_word_sequencer
    import rca_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = RCA_SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = rca_cnt_w(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    rca_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   sum_d;

    ripple_carry_adder #(
        .W (SLICE_W)
    ) u_slice_adder (
        .a_i    (a_q[SLICE_W-1:0]),
        .b_i    (b_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .cout_o (slice_cout_s)
    );

    // New slice enters at the MSB end so slice 0 lands at the bottom after NSLICE shifts.
    always_comb begin
        sum_d = (sum_q >> SLICE_W) | (WIDTH'(slice_sum_s) << (WIDTH - SLICE_W));
    end

    // Sequencer FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE_W;
                    b_q     <= b_q >> SLICE_W;
                    sum_q   <= sum_d;
                    carry_q <= slice_cout_s;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= '0;
                        cout_q      <= slice_cout_s;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Self-checking bench: directed table + scoreboard on a 16-bit instance,
// random back-to-back stream, and exhaustive sweep of a single-slice instance.
module tb_rca_word_sequencer;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        v4_in_valid, v4_in_ready, v4_cin, v4_out_valid, v4_out_ready, v4_cout, v4_busy;
    logic [3:0]  v4_a, v4_b, v4_sum;

    int n_pass  = 0;
    int n_total = 0;

    logic [16:0] q16[$];
    logic [4:0]  q4[$];

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    rca_word_sequencer #(.WIDTH(16), .SLICE_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    rca_word_sequencer #(.WIDTH(4), .SLICE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .a(v4_a), .b(v4_b), .cin(v4_cin), .out_valid(v4_out_valid), .out_ready(v4_out_ready),
        .sum(v4_sum), .cout(v4_cout), .busy(v4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run16(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [16:0] texp, input int hold);
        int          lat;
        logic        hs_bad;
        logic [16:0] e;
        chk({nm, "_ready_idle"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        q16.push_back(texp);
        hs_bad = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if (out_valid) break;
            if (in_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
        end
        chk({nm, "_ready_low_run"}, {31'd0, hs_bad}, 32'd0);
        chk({nm, "_latency"}, 32'(lat - 1), 32'd4);
        if (out_valid) begin
            e = (q16.size() > 0) ? q16[0] : 17'd0;
            for (int k = 0; k < hold; k++) begin
                out_ready = 1'b0;
                in_valid = k[0] ? 1'b0 : 1'b1;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                @(negedge clk);
                chk({nm, "_hold"}, {13'd0, out_valid, in_ready, busy, cout, sum},
                    {13'd0, 1'b1, 1'b0, 1'b1, e});
            end
            in_valid = 1'b0;
            chk({nm, "_ready_low_done"}, {31'd0, in_ready}, 32'd0);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk({nm, "_result"}, {15'd0, cout, sum}, {15'd0, e});
            end else begin
                chk({nm, "_scoreboard_empty"}, 32'd0, 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({nm, "_consumed"}, {29'd0, out_valid, in_ready, busy}, {29'd0, 3'b010});
        end else begin
            void'(q16.pop_front());
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int          sent, got, cyc, last;
        logic [16:0] e;
        logic [4:0]  e4;

        vecs[0] = '{"ovf",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
        vecs[1] = '{"cin1",     16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0};
        vecs[2] = '{"zero",     16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        vecs[3] = '{"allones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
        vecs[4] = '{"msb",      16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
        vecs[5] = '{"chain",    16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 0};
        vecs[6] = '{"backpres", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 10};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        v4_in_valid = 1'b0; v4_out_ready = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {27'd0, in_ready, out_valid, busy, cout, |sum}, {27'd0, 5'b10000});
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run16(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
                  {vecs[i].exp_cout, vecs[i].exp_sum}, vecs[i].hold);

        // abort an operation after two slices, then run a fresh one
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_partial", {31'd0, |sum}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {27'd0, in_ready, out_valid, busy, cout, |sum}, {27'd0, 5'b10000});
        @(negedge clk);
        rst_n = 1'b1;
        run16("after_reset", 16'h00FF, 16'h0001, 1'b0, 17'h00100, 0);

        // random back-to-back stream with both handshakes held high
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0; last = -1;
        while (got < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    chk("b2b_result", {15'd0, cout, sum}, {15'd0, e});
                end else begin
                    chk("b2b_unexpected", 32'd0, 32'd1);
                end
                if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'd6);
                last = cyc;
                got++;
            end
            if (in_ready && sent < 256) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
                in_valid = 1'b1;
                q16.push_back(17'(a) + 17'(b) + 17'(cin));
                sent++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", 32'(got), 32'd256);

        // exhaustive single-slice instance
        @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            v4_a = 4'(k); v4_b = 4'(k >> 4); v4_cin = 1'(k >> 8);
            v4_in_valid = 1'b1;
            q4.push_back(5'(v4_a) + 5'(v4_b) + 5'(v4_cin));
            @(negedge clk);
            v4_in_valid = 1'b0;
            @(negedge clk);
            e4 = (q4.size() > 0) ? q4.pop_front() : 5'd0;
            chk("w4_result", {26'd0, v4_out_valid, v4_cout, v4_sum}, {26'd0, 1'b1, e4});
            v4_out_ready = 1'b1;
            @(negedge clk);
            v4_out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rca_word_sequencer.md
RCA_WORD_SEQUENCER -- requirements
Module: rca_word_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits; SHALL be an integer multiple of SLICE_W and at least SLICE_W.
REQ-002 Parameter SLICE_W, default 4: width of the ripple_carry_adder slice reused every cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand word presented.
REQ-006 in_ready  output  1  block can accept an operand word.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in of the full word.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, RUN, DONE; NSLICE = WIDTH/SLICE_W.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready capture a, b into shift registers, carry register <= cin, slice counter <= 0, go to RUN.
REQ-017 RUN: in_ready=0; each cycle add low SLICE_W bits of A and B plus carry register through one ripple_carry_adder; shift slice sum into the sum register from the MSB end; carry register <= slice carry-out; shift A and B right by SLICE_W; counter increments.
REQ-018 RUN lasts exactly NSLICE cycles; on the edge that processes slice NSLICE-1, go to DONE.
REQ-019 Latency: out_valid rises exactly NSLICE clock edges after the accepting edge (4 for WIDTH=16).
REQ-020 DONE: out_valid=1; sum holds the full result (slice 0 at bits SLICE_W-1:0); cout = final carry register; both stable while out_ready=0.
REQ-021 DONE with out_ready=1: result consumed on that edge, go to IDLE; in_ready SHALL NOT be asserted in DONE (no overlapped accept).
REQ-022 in_valid while not IDLE is ignored; a, b, cin changes during RUN/DONE have no effect on the in-flight result.
REQ-023 Counter width clog2(NSLICE) or wider; no wrap before the RUN->DONE transition; NSLICE=1 SHALL yield a single RUN cycle.
REQ-024 Arithmetic is unsigned; no overflow flag beyond cout.

Reset
REQ-025 rst_n low forces, asynchronously: state=IDLE, in_ready=1 after release, out_valid=0, busy=0, sum=0, cout=0, carry register=0, counter=0.
REQ-026 Reset during RUN or DONE aborts the operation; the partial result is discarded and never presented.
REQ-027 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package rca_pkg holds SLICE_W default constant and the FSM state enumeration (IDLE, RUN, DONE).
REQ-029 One sub-module instance: ripple_carry_adder #(SLICE_W), the existing adder, purely combinational; all registers live in rca_word_sequencer.

Verification
REQ-030 WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid 4 edges after accept.
REQ-031 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready low from accept until the result is consumed.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> sum/cout/out_valid unchanged; in_valid pulses with new data are ignored; result consumed on first out_ready=1.
REQ-033 Reset mid-RUN (after 2 slices): rst_n low -> outputs zero immediately; next operation a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0.
REQ-034 Back-to-back: out_ready tied 1, in_valid tied 1, 256 random operand sets -> every result equals {cout,sum} = a+b+cin; one result per NSLICE+2 cycles.
REQ-035 WIDTH=4 (NSLICE=1): exhaustive 512 {cin,b,a} combinations -> {cout,sum} = a+b+cin, latency 1 edge.
